// File: rtl/mac_frame_generator.sv
// mac_frame_generator: builds complete Ethernet frames on a 64-bit data /
// 8-bit control lane bus, one word per clock, with a CRC-32 FCS.
module mac_frame_generator #(
  parameter int          DATA_WIDTH    = 64,
  parameter int          CTRL_WIDTH    = 8,
  parameter logic [7:0]  IDLE_CODE     = 8'h07,
  parameter logic [7:0]  START_CODE    = 8'hFB,
  parameter logic [7:0]  TERM_CODE     = 8'hFD,
  parameter logic [7:0]  PREAMBLE_CODE = 8'h55,
  parameter logic [7:0]  SFD_CODE      = 8'hD5,
  parameter logic [47:0] DST_ADDR_CODE = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_ADDR_CODE = 48'h123456789ABC,
  parameter int          IPG_WORDS     = 1
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [10:0]           i_payload_len,
  input  logic [7:0]            i_payload_seed,
  input  logic                  i_pattern_mode,
  input  logic                  i_inject_fcs_err,
  output logic                  o_ready,
  output logic                  o_len_err,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
  output logic                  o_frame_done,
  output logic [15:0]           o_frame_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_BODY,
    S_TAIL
  } state_e;

  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {8{IDLE_CODE}};
  localparam logic [DATA_WIDTH-1:0] PRE_WORD =
    {SFD_CODE, {6{PREAMBLE_CODE}}, START_CODE};
  localparam logic [7:0] IPG_LAST = 8'(IPG_WORDS - 1);

  state_e                state_q, state_d;
  logic [11:0]           pos_q, pos_d;
  logic [10:0]           len_q, len_d;
  logic [7:0]            seed_q, seed_d;
  logic                  mode_q, mode_d;
  logic                  inj_q, inj_d;
  logic [31:0]           crc_q, crc_d;
  logic [7:0]            ipg_q, ipg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic                  ready_q, ready_d;
  logic                  len_err_q, len_err_d;
  logic                  done_q, done_d;
  logic [15:0]           count_q, count_d;

  logic [11:0]           body_len;
  logic [11:0]           lane_idx [8];
  logic [7:0]            lane_b [8];
  logic [31:0]           crc_w;
  logic [31:0]           fcs;
  logic [DATA_WIDTH-1:0] wd;
  logic [CTRL_WIDTH-1:0] wc;
  logic                  last_word;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] body_byte(
    input logic [11:0] i,
    input logic [10:0] n,
    input logic [7:0]  s,
    input logic        m
  );
    logic [11:0] p;
    logic [11:0] q;
    logic [7:0]  r;
    p = i - 12'd14;
    q = i - 12'd6;
    if (i < 12'd6)
      r = 8'(DST_ADDR_CODE >> {i[2:0], 3'b000});
    else if (i < 12'd12)
      r = 8'(SRC_ADDR_CODE >> {q[2:0], 3'b000});
    else if (i == 12'd12)
      r = n[7:0];
    else if (i == 12'd13)
      r = {5'b0, n[10:8]};
    else if (p < {1'b0, n})
      r = m ? s : s + p[7:0];
    else
      r = 8'h00;
    return r;
  endfunction

  // Word builder: CRC folds in only this word's body lanes, so the FCS
  // bytes that follow in the same word already see the final value.
  always_comb begin
    body_len = (len_q < 11'd46) ? 12'd60 : {1'b0, len_q} + 12'd14;
    crc_w    = crc_q;
    for (int i = 0; i < 8; i++) begin
      lane_idx[i] = pos_q + 12'(i);
      lane_b[i]   = body_byte(lane_idx[i], len_q, seed_q, mode_q);
      if (lane_idx[i] < body_len)
        crc_w = crc_byte(crc_w, lane_b[i]);
    end
    fcs = ~crc_w;
    if (inj_q)
      fcs[0] = ~fcs[0];
    wd = IDLE_WORD;
    wc = '1;
    for (int i = 0; i < 8; i++) begin
      if (lane_idx[i] < body_len) begin
        wd[8*i +: 8] = lane_b[i];
        wc[i]        = 1'b0;
      end else if (lane_idx[i] < body_len + 12'd4) begin
        wd[8*i +: 8] =
          8'(fcs >> {lane_idx[i][1:0] - body_len[1:0], 3'b000});
        wc[i]        = 1'b0;
      end else if (lane_idx[i] == body_len + 12'd4) begin
        wd[8*i +: 8] = TERM_CODE;
      end
    end
    last_word = (pos_q + 12'd8) > (body_len + 12'd4);
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    len_d     = len_q;
    seed_d    = seed_q;
    mode_d    = mode_q;
    inj_d     = inj_q;
    crc_d     = crc_q;
    ipg_d     = ipg_q;
    data_d    = IDLE_WORD;
    ctrl_d    = '1;
    len_err_d = 1'b0;
    done_d    = 1'b0;
    count_d   = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_payload_len > 11'd1500) begin
            len_err_d = 1'b1;
          end else begin
            state_d = S_PRE;
            len_d   = i_payload_len;
            seed_d  = i_payload_seed;
            mode_d  = i_pattern_mode;
            inj_d   = i_inject_fcs_err;
            pos_d   = '0;
            crc_d   = 32'hFFFFFFFF;
            data_d  = PRE_WORD;
            ctrl_d  = 8'h01;
          end
        end
      end
      S_PRE, S_BODY: begin
        state_d = S_BODY;
        data_d  = wd;
        ctrl_d  = wc;
        crc_d   = crc_w;
        pos_d   = pos_q + 12'd8;
        if (last_word) begin
          state_d = S_TAIL;
          done_d  = 1'b1;
          count_d = count_q + 16'd1;
          ipg_d   = '0;
        end
      end
      S_TAIL: begin
        ipg_d = ipg_q + 8'd1;
        if (ipg_q == IPG_LAST)
          state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pos_q     <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      mode_q    <= 1'b0;
      inj_q     <= 1'b0;
      crc_q     <= 32'hFFFFFFFF;
      ipg_q     <= '0;
      data_q    <= IDLE_WORD;
      ctrl_q    <= '1;
      ready_q   <= 1'b1;
      len_err_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      len_q     <= len_d;
      seed_q    <= seed_d;
      mode_q    <= mode_d;
      inj_q     <= inj_d;
      crc_q     <= crc_d;
      ipg_q     <= ipg_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      ready_q   <= ready_d;
      len_err_q <= len_err_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_len_err     = len_err_q;
  assign o_tx_data     = data_q;
  assign o_tx_ctrl     = ctrl_q;
  assign o_frame_done  = done_q;
  assign o_frame_count = count_q;

endmodule

// File: tb/tb_mac_frame_generator.sv
// tb_mac_frame_generator: directed frame scenarios checked against
// hand-computed words and a byte-level frame model.
module tb_mac_frame_generator;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [10:0] i_payload_len;
  logic [7:0]  i_payload_seed;
  logic        i_pattern_mode;
  logic        i_inject_fcs_err;
  logic        o_ready;
  logic        o_len_err;
  logic [63:0] o_tx_data;
  logic [7:0]  o_tx_ctrl;
  logic        o_frame_done;
  logic [15:0] o_frame_count;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;

  logic [63:0] cap_d [$];
  logic [7:0]  cap_c [$];
  logic [7:0]  cq [$];
  logic [63:0] exp_d [$];
  logic [7:0]  exp_c [$];
  logic [7:0]  mq [$];
  logic [31:0] ref_crc;
  int          done_cnt;
  logic        done_at_term;
  logic        timed_out;

  mac_frame_generator dut (
    .clk              (clk),
    .i_rst            (i_rst),
    .i_start          (i_start),
    .i_payload_len    (i_payload_len),
    .i_payload_seed   (i_payload_seed),
    .i_pattern_mode   (i_pattern_mode),
    .i_inject_fcs_err (i_inject_fcs_err),
    .o_ready          (o_ready),
    .o_len_err        (o_len_err),
    .o_tx_data        (o_tx_data),
    .o_tx_ctrl        (o_tx_ctrl),
    .o_frame_done     (o_frame_done),
    .o_frame_count    (o_frame_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] crc_b(input logic [31:0] c,
                                        input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Reference frame: byte stream DA..FCS, then packed into lane words.
  task automatic build_model(input int n, input logic [7:0] seed,
                             input logic mode, input logic inj);
    logic [47:0] da;
    logic [47:0] sa;
    logic [31:0] c;
    logic [63:0] wd;
    logic [7:0]  wc;
    logic [7:0]  b;
    int          d, nw, p;
    da = 48'hFFFFFFFFFFFF;
    sa = 48'h123456789ABC;
    mq.delete();
    exp_d.delete();
    exp_c.delete();
    for (int k = 0; k < 6; k++) mq.push_back(da[8*k +: 8]);
    for (int k = 0; k < 6; k++) mq.push_back(sa[8*k +: 8]);
    mq.push_back(n[7:0]);
    mq.push_back(n[15:8]);
    d = (n < 46) ? 46 : n;
    for (int j = 0; j < d; j++) begin
      if (j >= n) b = 8'h00;
      else if (mode) b = seed;
      else b = seed + j[7:0];
      mq.push_back(b);
    end
    c = 32'hFFFFFFFF;
    foreach (mq[i]) c = crc_b(c, mq[i]);
    c = ~c;
    ref_crc = c;
    if (inj) c[0] = ~c[0];
    for (int k = 0; k < 4; k++) mq.push_back(c[8*k +: 8]);
    exp_d.push_back(PRE_W);
    exp_c.push_back(8'h01);
    nw = (mq.size() + 1 + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      wd = '0;
      wc = '0;
      for (int l = 0; l < 8; l++) begin
        p = w * 8 + l;
        if (p < mq.size()) begin
          wd[8*l +: 8] = mq[p];
        end else if (p == mq.size()) begin
          wd[8*l +: 8] = 8'hFD;
          wc[l] = 1'b1;
        end else begin
          wd[8*l +: 8] = 8'h07;
          wc[l] = 1'b1;
        end
      end
      exp_d.push_back(wd);
      exp_c.push_back(wc);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!o_ready && k < 30) begin
      tick();
      k++;
    end
    total++;
    if (!o_ready) begin
      bad++;
      $display("FAIL wait_ready got=%0b want=1", o_ready);
    end
  endtask

  // Requests a frame, scrambles the inputs right after acceptance, and
  // records every word up to the one carrying control lanes.
  task automatic run_frame(input int n, input logic [7:0] seed,
                           input logic mode, input logic inj);
    wait_ready();
    cap_d.delete();
    cap_c.delete();
    cq.delete();
    done_cnt     = 0;
    done_at_term = 1'b0;
    timed_out    = 1'b1;
    i_payload_len    = 11'(n);
    i_payload_seed   = seed;
    i_pattern_mode   = mode;
    i_inject_fcs_err = inj;
    i_start          = 1'b1;
    tick();
    i_start          = 1'b0;
    i_payload_len    = 11'd5;
    i_payload_seed   = ~seed;
    i_pattern_mode   = ~mode;
    i_inject_fcs_err = ~inj;
    cap_d.push_back(o_tx_data);
    cap_c.push_back(o_tx_ctrl);
    for (int t = 0; t < 250; t++) begin
      tick();
      cap_d.push_back(o_tx_data);
      cap_c.push_back(o_tx_ctrl);
      if (o_frame_done) done_cnt++;
      for (int l = 0; l < 8; l++)
        if (!o_tx_ctrl[l]) cq.push_back(o_tx_data[8*l +: 8]);
      if (o_tx_ctrl != 8'h00) begin
        done_at_term = o_frame_done;
        timed_out = 1'b0;
        break;
      end
    end
    total++;
    if (timed_out) begin
      bad++;
      $display("FAIL frame_end n=%0d got=timeout want=term", n);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_start = 1'b0;
    i_payload_len = '0;
    i_payload_seed = '0;
    i_pattern_mode = 1'b0;
    i_inject_fcs_err = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    total++;
    if (o_tx_data !== IDLE_W) begin
      bad++; $display("FAIL rst_data got=%h want=%h", o_tx_data, IDLE_W);
    end
    total++;
    if (o_tx_ctrl !== 8'hFF) begin
      bad++; $display("FAIL rst_ctrl got=%h want=ff", o_tx_ctrl);
    end
    total++;
    if (o_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b want=1", o_ready);
    end
    total++;
    if (o_frame_count !== 16'd0) begin
      bad++; $display("FAIL rst_count got=%0d want=0", o_frame_count);
    end
    total++;
    if (o_len_err !== 1'b0 || o_frame_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_pulses got=%b%b want=00", o_len_err, o_frame_done);
    end
  endtask

  task automatic test_reset_mid();
    i_payload_len = 11'd100;
    i_payload_seed = 8'h10;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    total++;
    if (o_tx_ctrl !== 8'h00) begin
      bad++; $display("FAIL mid_body got=%h want=00", o_tx_ctrl);
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    total++;
    if (o_tx_data !== IDLE_W || o_tx_ctrl !== 8'hFF) begin
      bad++;
      $display("FAIL mid_idle got=%h/%h want=%h/ff", o_tx_data, o_tx_ctrl,
               IDLE_W);
    end
    total++;
    if (o_ready !== 1'b1) begin
      bad++; $display("FAIL mid_ready got=%b want=1", o_ready);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (o_tx_data !== IDLE_W || o_frame_done !== 1'b0 ||
          o_frame_count !== 16'd0) begin
        bad++;
        $display("FAIL mid_after%0d got=%h/%b/%0d want=%h/0/0", k,
                 o_tx_data, o_frame_done, o_frame_count, IDLE_W);
      end
    end
  endtask

  task automatic test_n46();
    logic [31:0] c;
    run_frame(46, 8'h00, 1'b0, 1'b0);
    build_model(46, 8'h00, 1'b0, 1'b0);
    total++;
    if (cap_d.size() != 10) begin
      bad++; $display("FAIL n46_words got=%0d want=10", cap_d.size());
    end
    total++;
    if (cap_d[0] !== PRE_W || cap_c[0] !== 8'h01) begin
      bad++;
      $display("FAIL n46_pre got=%h/%h want=%h/01", cap_d[0], cap_c[0],
               PRE_W);
    end
    total++;
    if (cap_d[1] !== 64'h9ABCFFFFFFFFFFFF || cap_c[1] !== 8'h00) begin
      bad++; $display("FAIL n46_w1 got=%h want=9abcffffffffffff", cap_d[1]);
    end
    total++;
    if (cap_d[2] !== 64'h0100002E12345678) begin
      bad++; $display("FAIL n46_w2 got=%h want=0100002e12345678", cap_d[2]);
    end
    total++;
    if (cap_d[cap_d.size()-1] !== 64'h07070707070707FD ||
        cap_c[cap_c.size()-1] !== 8'hFF) begin
      bad++;
      $display("FAIL n46_last got=%h/%h want=07070707070707fd/ff",
               cap_d[cap_d.size()-1], cap_c[cap_c.size()-1]);
    end
    c = 32'hFFFFFFFF;
    foreach (cq[i]) c = crc_b(c, cq[i]);
    total++;
    if (c !== 32'hDEBB20E3) begin
      bad++; $display("FAIL n46_residue got=%h want=debb20e3", c);
    end
    total++;
    if (done_cnt != 1 || done_at_term !== 1'b1) begin
      bad++;
      $display("FAIL n46_done got=%0d/%b want=1/1", done_cnt, done_at_term);
    end
    total++;
    if (o_frame_count !== 16'd1) begin
      bad++; $display("FAIL n46_count got=%0d want=1", o_frame_count);
    end
    foreach (exp_d[i]) if (i < cap_d.size()) begin
      total++;
      if (cap_d[i] !== exp_d[i] || cap_c[i] !== exp_c[i]) begin
        bad++;
        $display("FAIL n46_word%0d got=%h/%h want=%h/%h", i, cap_d[i],
                 cap_c[i], exp_d[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_n48_const();
    logic [63:0] want;
    run_frame(48, 8'h5A, 1'b1, 1'b0);
    build_model(48, 8'h5A, 1'b1, 1'b0);
    want = {40'h0707070707, 8'hFD, ref_crc[31:24], ref_crc[23:16]};
    total++;
    if (cap_d.size() != 10) begin
      bad++; $display("FAIL n48_words got=%0d want=10", cap_d.size());
    end
    total++;
    if (cap_d[cap_d.size()-1] !== want ||
        cap_c[cap_c.size()-1] !== 8'hFC) begin
      bad++;
      $display("FAIL n48_last got=%h/%h want=%h/fc",
               cap_d[cap_d.size()-1], cap_c[cap_c.size()-1], want);
    end
    total++;
    if (o_frame_count !== 16'd2) begin
      bad++; $display("FAIL n48_count got=%0d want=2", o_frame_count);
    end
    foreach (exp_d[i]) if (i < cap_d.size()) begin
      total++;
      if (cap_d[i] !== exp_d[i] || cap_c[i] !== exp_c[i]) begin
        bad++;
        $display("FAIL n48_word%0d got=%h/%h want=%h/%h", i, cap_d[i],
                 cap_c[i], exp_d[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_n43_pad();
    run_frame(43, 8'hA0, 1'b0, 1'b0);
    build_model(43, 8'hA0, 1'b0, 1'b0);
    total++;
    if (cap_d.size() != 10) begin
      bad++; $display("FAIL n43_words got=%0d want=10", cap_d.size());
    end
    total++;
    if (cap_d[2] !== 64'hA1A0002B12345678) begin
      bad++; $display("FAIL n43_w2 got=%h want=a1a0002b12345678", cap_d[2]);
    end
    total++;
    if (cq.size() != 64 || cq[57] !== 8'h00 || cq[58] !== 8'h00 ||
        cq[59] !== 8'h00 || cq[56] !== 8'hCA) begin
      bad++;
      $display("FAIL n43_pad got=%h %h %h %h want=ca 00 00 00", cq[56],
               cq[57], cq[58], cq[59]);
    end
    foreach (exp_d[i]) if (i < cap_d.size()) begin
      total++;
      if (cap_d[i] !== exp_d[i] || cap_c[i] !== exp_c[i]) begin
        bad++;
        $display("FAIL n43_word%0d got=%h/%h want=%h/%h", i, cap_d[i],
                 cap_c[i], exp_d[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_fcs_err();
    logic [31:0] got_fcs;
    logic [31:0] c;
    run_frame(64, 8'h21, 1'b0, 1'b1);
    build_model(64, 8'h21, 1'b0, 1'b0);
    total++;
    if (cq.size() != 82) begin
      bad++; $display("FAIL fcs_bytes got=%0d want=82", cq.size());
    end
    got_fcs = {cq[81], cq[80], cq[79], cq[78]};
    total++;
    if ((got_fcs ^ ref_crc) !== 32'h00000001) begin
      bad++;
      $display("FAIL fcs_flip got=%h want=%h", got_fcs,
               ref_crc ^ 32'h1);
    end
    c = 32'hFFFFFFFF;
    foreach (cq[i]) c = crc_b(c, cq[i]);
    total++;
    if (c === 32'hDEBB20E3) begin
      bad++; $display("FAIL fcs_residue got=%h want=not debb20e3", c);
    end
  endtask

  task automatic test_back_to_back();
    int idles;
    logic seen;
    wait_ready();
    i_payload_len = 11'd1501;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    total++;
    if (o_len_err !== 1'b1 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL lenerr_pulse got=%b/%b want=1/1", o_len_err, o_ready);
    end
    total++;
    if (o_tx_ctrl !== 8'hFF || o_tx_data !== IDLE_W) begin
      bad++; $display("FAIL lenerr_nopre got=%h want=ff", o_tx_ctrl);
    end
    tick();
    total++;
    if (o_len_err !== 1'b0 || o_tx_ctrl !== 8'hFF) begin
      bad++;
      $display("FAIL lenerr_clear got=%b/%h want=0/ff", o_len_err,
               o_tx_ctrl);
    end
    run_frame(1500, 8'h33, 1'b0, 1'b0);
    build_model(1500, 8'h33, 1'b0, 1'b0);
    total++;
    if (cap_d.size() != exp_d.size()) begin
      bad++;
      $display("FAIL n1500_words got=%0d want=%0d", cap_d.size(),
               exp_d.size());
    end
    foreach (exp_d[i]) if (i < cap_d.size()) begin
      total++;
      if (cap_d[i] !== exp_d[i] || cap_c[i] !== exp_c[i]) begin
        bad++;
        $display("FAIL n1500_word%0d got=%h/%h want=%h/%h", i, cap_d[i],
                 cap_c[i], exp_d[i], exp_c[i]);
      end
    end
    i_payload_len = 11'd46;
    i_payload_seed = 8'h07;
    i_pattern_mode = 1'b0;
    i_inject_fcs_err = 1'b0;
    i_start = 1'b1;
    idles = 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_tx_data === PRE_W && o_tx_ctrl === 8'h01) begin
        seen = 1'b1;
        break;
      end
      if (o_tx_data === IDLE_W && o_tx_ctrl === 8'hFF) idles++;
    end
    i_start = 1'b0;
    total++;
    if (!seen || idles != 1) begin
      bad++; $display("FAIL b2b_gap got=%0d/%b want=1/1", idles, seen);
    end
    for (int k = 0; k < 12; k++) tick();
    total++;
    if (o_frame_count !== 16'd6) begin
      bad++; $display("FAIL b2b_count got=%0d want=6", o_frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_n46();
    test_n48_const();
    test_n43_pad();
    test_fcs_err();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_frame_generator.md
Name: mac_frame_generator

Overview:
Transmit-side counterpart of the MAC frame checker. It builds complete Ethernet frames on a 64-bit data / 8-bit control MII-style lane bus, one word per clock. Each frame carries start, preamble, SFD, DA, SA, length/type, a generated payload with zero padding, FCS and terminate, followed by idles. It is the stimulus source for the checker and for the PCS/MII_BASE-R path.

Parameters:
DATA_WIDTH, 64, output data width; lane i = bits [8i+7:8i]; only 64 supported
CTRL_WIDTH, 8, one control bit per lane; only 8 supported
IDLE_CODE, 8'h07, idle control character
START_CODE, 8'hFB, start control character (lane 0 only)
TERM_CODE, 8'hFD, terminate control character
PREAMBLE_CODE, 8'h55, preamble byte
SFD_CODE, 8'hD5, start frame delimiter
DST_ADDR_CODE, 48'hFFFFFFFFFFFF, destination address
SRC_ADDR_CODE, 48'h123456789ABC, source address
IPG_WORDS, 1, minimum all-idle words after the terminate word (>=1)

Ports:
clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  frame request; accepted only when o_ready=1
i_payload_len  in  11  payload length N in bytes, 0..1500
i_payload_seed  in  8  first payload byte value
i_pattern_mode  in  1  0: incrementing bytes; 1: constant seed
i_inject_fcs_err  in  1  invert bit 0 of emitted FCS byte 0
o_ready  out  1  generator idle and IPG satisfied
o_len_err  out  1  one-cycle pulse: request rejected (N>1500)
o_tx_data  out  DATA_WIDTH  lane data
o_tx_ctrl  out  CTRL_WIDTH  lane control flags (1 = control character)
o_frame_done  out  1  one-cycle pulse aligned with the terminate word
o_frame_count  out  16  frames completed, wraps at 65535->0

Behaviour:
- Reset (i_rst=1 at a clk edge): state IDLE. o_tx_data=64'h0707070707070707, o_tx_ctrl=8'hFF, o_ready=1, o_len_err=0, o_frame_done=0, o_frame_count=0. Reset mid-frame aborts the frame at once: no terminate, no count increment, idles on the next cycle.
- All outputs are registered. A frame request is sampled on the clock edge where i_start=1 and o_ready=1. N, seed, mode and inject are latched at that edge; later input changes have no effect on the frame in progress.
- N>1500 at request: no frame is sent; o_len_err=1 for one cycle; o_ready stays 1.
- States and transitions:
  - IDLE -> PRE on an accepted request.
  - PRE -> BODY after one word.
  - BODY -> TAIL when the terminate word is emitted.
  - TAIL -> IDLE after IPG_WORDS idle words.
- o_ready=1 only in IDLE.
- PRE word: {SFD, 6x PREAMBLE, START} with START in lane 0, ctrl=8'h01. It appears on the output one cycle after acceptance.
- Body byte order:
  - DA, then SA, then the length/type field (16 bits, value = N, not the padded length), then payload, then padding.
  - Every multi-byte field is emitted least-significant byte first: byte k = field[8k+7:8k].
  - Body size D = max(N,46); bytes N..45 are 8'h00.
  - Payload byte j = seed+j mod 256 in mode 0, or seed in mode 1.
- B = 14+D body bytes follow the PRE word. Then 4 FCS bytes, then TERM, then IDLE fill to the end of the word.
- Post-PRE word count W = ceil((B+5)/8).
- Ctrl bits are set for the TERM lane and all higher lanes of the last word; all data lanes have ctrl 0.
- FCS: IEEE 802.3 CRC-32 (reflected, poly 0x04C11DB7, init 0xFFFFFFFF, final complement) over DA..pad.
  - FCS byte k = crc[8k+7:8k].
  - CRC is updated per word over only the body lanes of that word, so body, FCS and TERM may share a word.
- o_frame_done pulses and o_frame_count increments in the cycle the TERM-bearing word is on the output.
- i_start while o_ready=0 is ignored; it is not queued.
- A request accepted in the first cycle o_ready returns gives a PRE word immediately after the IPG_WORDS idle words.

Test Plan:
- Reset with i_rst=1 for 2 cycles -> idle word 0x0707070707070707, ctrl 0xFF, o_ready=1, count 0.
- N=46, seed 0x00, mode 0:
  - PRE word 0xD5555555555555FB, ctrl 0x01.
  - Then 9 words; word 1 = 0xFFFFFFFFFFFF then 0xBC,0x9A in lanes 6-7.
  - Last word lane0=FD, lanes1-7=07, ctrl 0xFF.
  - CRC over DA..FCS gives residue 0xDEBB20E3.
  - o_frame_done pulses once; count becomes 1.
- N=48 -> last word lanes0-1 = FCS bytes 2,3, lane2=FD, ctrl 0xFC, 10 words total including PRE.
- N=43, seed 0xA0 -> length bytes 0x2B,0x00 in word 2 lanes 4-5; bytes 43..45 are 0x00; D=46 framing identical to N=46.
- i_inject_fcs_err=1, N=64 -> FCS byte 0 differs from the reference CRC only in bit 0; an independent CRC model flags a mismatch.
- N=1501 -> o_len_err pulse, no PRE word. Then N=1500 back-to-back with IPG_WORDS=1 -> exactly one idle word between frames.
- i_rst asserted during a BODY word -> idle next cycle, no TERM, count unchanged.
